cdb_arbiter: RTL and testbench

- Shares the single ROB result-write port (the b2/b4 write path) between two producers: the RS execution path (ALU/branch results) and the SLB (load results).
- Each producer gets a small FIFO. The arbiter grants at most one result per cycle, round-robin, onto a common data bus.
- The bus drives the ROB value/ready/jumppc write and the RS/SLB operand wakeup.
- Outputs are flushed on the global Clear_flag.

---
 rtl/cdb_arbiter_pkg.sv | 16 +
 rtl/cdb_fifo.sv | 69 ++++++
 rtl/cdb_arbiter.sv | 104 ++++++++++
 tb/tb_cdb_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and source encodings for the common data bus arbiter.
// Also holds the round-robin pick function used by cdb_arbiter.
package cdb_arbiter_pkg;

  localparam int ROB_LR_WIDTH = 4;
  localparam int DATA_WIDTH   = 32;

  localparam logic CDB_SRC_RS  = 1'b0;
  localparam logic CDB_SRC_SLB = 1'b1;

  // SLB wins when it is the only candidate or when it holds the priority token.
  function automatic logic pick_slb(input logic alu_ne, input logic lsu_ne, input logic pri);
    return lsu_ne && (!alu_ne || (pri == CDB_SRC_SLB));
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small synchronous FIFO buffering one producer's results for the CDB.
// Freezes completely while rdy is low; flush empties it in a single edge.
module cdb_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PTR_W'(1);
      if (do_pop)  rd_d = rd_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (rdy) begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && !flush && do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the ROB result-write port between the RS
// execution path and the SLB, with one small FIFO per producer.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_W  = ROB_LR_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              Clear_flag,
  input  logic              alu_valid,
  input  logic [ROB_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_value,
  input  logic [DATA_W-1:0] alu_jumppc,
  input  logic              alu_jumppc_valid,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ROB_W-1:0]  lsu_tag,
  input  logic [DATA_W-1:0] lsu_value,
  output logic              lsu_ready,
  output logic              cdb_valid,
  output logic [ROB_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_value,
  output logic [DATA_W-1:0] cdb_jumppc,
  output logic              cdb_jumppc_valid,
  output logic              cdb_src
);

  localparam int ENTRY_W = ROB_W + 2 * DATA_W + 1;

  logic [ENTRY_W-1:0] alu_din, lsu_din, alu_head, lsu_head, sel_head;
  logic alu_empty, alu_full, lsu_empty, lsu_full;
  logic alu_push, lsu_push, alu_pop, lsu_pop;
  logic grant_slb;
  logic pri_q;

  assign alu_din = {alu_tag, alu_value, alu_jumppc, alu_jumppc_valid};
  assign lsu_din = {lsu_tag, lsu_value, {DATA_W{1'b0}}, 1'b0};

  assign alu_ready = rdy && !alu_full;
  assign lsu_ready = rdy && !lsu_full;
  assign alu_push  = alu_valid && alu_ready && !Clear_flag;
  assign lsu_push  = lsu_valid && lsu_ready && !Clear_flag;

  assign grant_slb = pick_slb(!alu_empty, !lsu_empty, pri_q);
  assign sel_head  = grant_slb ? lsu_head : alu_head;

  // A broadcast during a flush is left in place; the flush empties both FIFOs anyway.
  assign alu_pop = cdb_valid && !grant_slb && !Clear_flag;
  assign lsu_pop = cdb_valid &&  grant_slb && !Clear_flag;

  always_comb begin
    cdb_valid        = 1'b0;
    cdb_tag          = '0;
    cdb_value        = '0;
    cdb_jumppc       = '0;
    cdb_jumppc_valid = 1'b0;
    cdb_src          = CDB_SRC_RS;
    if (rdy && (!alu_empty || !lsu_empty)) begin
      cdb_valid = 1'b1;
      {cdb_tag, cdb_value, cdb_jumppc, cdb_jumppc_valid} = sel_head;
      cdb_src   = grant_slb ? CDB_SRC_SLB : CDB_SRC_RS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q <= CDB_SRC_RS;
    end else if (rdy) begin
      if (Clear_flag)     pri_q <= CDB_SRC_RS;
      else if (cdb_valid) pri_q <= ~cdb_src;
    end
  end

  cdb_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (Clear_flag),
    .push  (alu_push),
    .pop   (alu_pop),
    .din   (alu_din),
    .dout  (alu_head),
    .empty (alu_empty),
    .full  (alu_full)
  );

  cdb_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_lsu_fifo (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (Clear_flag),
    .push  (lsu_push),
    .pop   (lsu_pop),
    .din   (lsu_din),
    .dout  (lsu_head),
    .empty (lsu_empty),
    .full  (lsu_full)
  );

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin, backpressure,
// flush, freeze and pointer wrap, each with hand-derived bus sequences.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, Clear_flag;
  logic        alu_valid, alu_jumppc_valid, lsu_valid;
  logic [3:0]  alu_tag, lsu_tag;
  logic [31:0] alu_value, alu_jumppc, lsu_value;
  logic        alu_ready, lsu_ready;
  logic        cdb_valid, cdb_jumppc_valid, cdb_src;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value, cdb_jumppc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.ROB_W(4), .DATA_W(32), .DEPTH(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .Clear_flag       (Clear_flag),
    .alu_valid        (alu_valid),
    .alu_tag          (alu_tag),
    .alu_value        (alu_value),
    .alu_jumppc       (alu_jumppc),
    .alu_jumppc_valid (alu_jumppc_valid),
    .alu_ready        (alu_ready),
    .lsu_valid        (lsu_valid),
    .lsu_tag          (lsu_tag),
    .lsu_value        (lsu_value),
    .lsu_ready        (lsu_ready),
    .cdb_valid        (cdb_valid),
    .cdb_tag          (cdb_tag),
    .cdb_value        (cdb_value),
    .cdb_jumppc       (cdb_jumppc),
    .cdb_jumppc_valid (cdb_jumppc_valid),
    .cdb_src          (cdb_src)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_tag = 0; alu_value = 0; alu_jumppc = 0; alu_jumppc_valid = 0;
    lsu_valid = 0; lsu_tag = 0; lsu_value = 0; Clear_flag = 0; rdy = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_cdb_valid got=%0b exp=0", cdb_valid); end
    checks++;
    if ({cdb_tag, cdb_value, cdb_jumppc, cdb_jumppc_valid, cdb_src} !== '0) begin
      errors++; $display("[TB] FAIL reset_cdb_data got tag=%0d val=%h jpc=%h", cdb_tag, cdb_value, cdb_jumppc);
    end
    checks++;
    if ({alu_ready, lsu_ready} !== 2'b11) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=11", {alu_ready, lsu_ready}); end
  endtask

  task automatic test_single_push();
    alu_valid = 1; alu_tag = 3; alu_value = 32'h11; alu_jumppc = 32'h80; alu_jumppc_valid = 1;
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_no_bypass got=%0b exp=0", cdb_valid); end
    step();
    alu_valid = 0; alu_jumppc_valid = 0;
    checks++;
    if ({cdb_valid, cdb_tag, cdb_value, cdb_src} !== {1'b1, 4'd3, 32'h11, 1'b0}) begin
      errors++; $display("[TB] FAIL single_bus got v=%0b tag=%0d val=%h src=%0b exp v=1 tag=3 val=11 src=0", cdb_valid, cdb_tag, cdb_value, cdb_src);
    end
    checks++;
    if ({cdb_jumppc, cdb_jumppc_valid} !== {32'h80, 1'b1}) begin
      errors++; $display("[TB] FAIL single_jumppc got=%h/%0b exp=80/1", cdb_jumppc, cdb_jumppc_valid);
    end
    step();
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_once got=%0b exp=0", cdb_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_tag [4] = '{4'd1, 4'd5, 4'd2, 4'd6};
    logic       exp_src [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    alu_valid = 1; alu_tag = 1; alu_value = 32'hA1;
    lsu_valid = 1; lsu_tag = 5; lsu_value = 32'hB5;
    step();
    alu_tag = 2; alu_value = 32'hA2; lsu_tag = 6; lsu_value = 32'hB6;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({cdb_valid, cdb_tag, cdb_src} !== {1'b1, exp_tag[i], exp_src[i]}) begin
        errors++; $display("[TB] FAIL rr_slot%0d got v=%0b tag=%0d src=%0b exp tag=%0d src=%0b", i, cdb_valid, cdb_tag, cdb_src, exp_tag[i], exp_src[i]);
      end
      if (i == 1) begin
        checks++;
        if (lsu_ready !== 1'b0) begin errors++; $display("[TB] FAIL rr_lsu_full got=%0b exp=0", lsu_ready); end
      end
      step();
      alu_valid = 0; lsu_valid = 0;
    end
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("[TB] FAIL rr_drained got=%0b exp=0", cdb_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    alu_valid = 1; alu_tag = 10; lsu_valid = 1; lsu_tag = 4; lsu_value = 32'h20;
    alu_jumppc = 32'h1234; alu_jumppc_valid = 1;
    step();
    checks++;
    if ({cdb_tag, cdb_src} !== {4'd10, 1'b0}) begin errors++; $display("[TB] FAIL bp_c1 got tag=%0d src=%0b exp 10/0", cdb_tag, cdb_src); end
    alu_tag = 11; lsu_tag = 5; lsu_value = 32'h21;
    step();
    alu_valid = 0; lsu_tag = 6; lsu_value = 32'h22;
    checks++;
    if (lsu_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_ready got=%0b exp=0", lsu_ready); end
    checks++;
    if ({cdb_tag, cdb_value, cdb_src, cdb_jumppc, cdb_jumppc_valid} !== {4'd4, 32'h20, 1'b1, 32'h0, 1'b0}) begin
      errors++; $display("[TB] FAIL bp_c2 got tag=%0d val=%h src=%0b jpc=%h/%0b exp 4/20/1/0/0", cdb_tag, cdb_value, cdb_src, cdb_jumppc, cdb_jumppc_valid);
    end
    step();
    checks++;
    if ({lsu_ready, cdb_tag, cdb_src} !== {1'b1, 4'd11, 1'b0}) begin
      errors++; $display("[TB] FAIL bp_c3 got rdy=%0b tag=%0d src=%0b exp 1/11/0", lsu_ready, cdb_tag, cdb_src);
    end
    step();
    lsu_valid = 0;
    checks++;
    if ({lsu_ready, cdb_tag, cdb_value, cdb_src} !== {1'b0, 4'd5, 32'h21, 1'b1}) begin
      errors++; $display("[TB] FAIL bp_c4 got rdy=%0b tag=%0d val=%h src=%0b exp 0/5/21/1", lsu_ready, cdb_tag, cdb_value, cdb_src);
    end
    step();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_value, cdb_src} !== {1'b1, 4'd6, 32'h22, 1'b1}) begin
      errors++; $display("[TB] FAIL bp_released got v=%0b tag=%0d val=%h src=%0b exp 1/6/22/1", cdb_valid, cdb_tag, cdb_value, cdb_src);
    end
    step();
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained got=%0b exp=0", cdb_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    alu_valid = 1; alu_tag = 0; lsu_valid = 1; lsu_tag = 8;
    step();
    alu_tag = 1; lsu_valid = 0;
    step();
    alu_tag = 2; lsu_valid = 1; lsu_tag = 9;
    step();
    alu_valid = 0; lsu_tag = 12; Clear_flag = 1;
    checks++;
    if ({cdb_valid, cdb_tag, cdb_src} !== {1'b1, 4'd1, 1'b0}) begin
      errors++; $display("[TB] FAIL flush_pre got v=%0b tag=%0d src=%0b exp 1/1/0", cdb_valid, cdb_tag, cdb_src);
    end
    step();
    Clear_flag = 0; lsu_valid = 0;
    checks++;
    if ({cdb_valid, alu_ready, lsu_ready} !== 3'b011) begin
      errors++; $display("[TB] FAIL flush_post got v=%0b ardy=%0b lrdy=%0b exp 0/1/1", cdb_valid, alu_ready, lsu_ready);
    end
    alu_valid = 1; alu_tag = 13; lsu_valid = 1; lsu_tag = 14;
    step();
    alu_valid = 0; lsu_valid = 0;
    checks++;
    if ({cdb_valid, cdb_tag, cdb_src} !== {1'b1, 4'd13, 1'b0}) begin
      errors++; $display("[TB] FAIL flush_pri got v=%0b tag=%0d src=%0b exp 1/13/0", cdb_valid, cdb_tag, cdb_src);
    end
    step();
    checks++;
    if ({cdb_valid, cdb_tag, cdb_src} !== {1'b1, 4'd14, 1'b1}) begin
      errors++; $display("[TB] FAIL flush_next got v=%0b tag=%0d src=%0b exp 1/14/1", cdb_valid, cdb_tag, cdb_src);
    end
    step();
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_drained got=%0b exp=0", cdb_valid); end
  endtask

  task automatic test_freeze();
    do_reset();
    alu_valid = 1; alu_tag = 7; alu_value = 32'h70;
    step();
    rdy = 0; alu_tag = 8; alu_value = 32'h80;
    for (int i = 0; i < 3; i++) begin
      Clear_flag = (i == 1);
      #1;
      checks++;
      if ({cdb_valid, alu_ready, lsu_ready} !== 3'b000) begin
        errors++; $display("[TB] FAIL freeze_c%0d got v=%0b ardy=%0b lrdy=%0b exp 0/0/0", i, cdb_valid, alu_ready, lsu_ready);
      end
      step();
    end
    rdy = 1; Clear_flag = 0;
    #1;
    checks++;
    if ({cdb_valid, cdb_tag, cdb_value, alu_ready} !== {1'b1, 4'd7, 32'h70, 1'b1}) begin
      errors++; $display("[TB] FAIL freeze_head got v=%0b tag=%0d val=%h ardy=%0b exp 1/7/70/1", cdb_valid, cdb_tag, cdb_value, alu_ready);
    end
    step();
    alu_valid = 0;
    checks++;
    if ({cdb_valid, cdb_tag, cdb_value} !== {1'b1, 4'd8, 32'h80}) begin
      errors++; $display("[TB] FAIL freeze_next got v=%0b tag=%0d val=%h exp 1/8/80", cdb_valid, cdb_tag, cdb_value);
    end
    step();
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("[TB] FAIL freeze_drained got=%0b exp=0", cdb_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      alu_valid = (i < 10);
      alu_tag   = 4'(i + 1);
      alu_value = 32'h100 + 32'(i);
      if (i == 0) begin
        checks++;
        if (cdb_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_first got=%0b exp=0", cdb_valid); end
      end else begin
        checks++;
        if ({cdb_valid, cdb_tag, cdb_value, alu_ready} !== {1'b1, 4'(i), 32'h100 + 32'(i - 1), 1'b1}) begin
          errors++; $display("[TB] FAIL wrap_%0d got v=%0b tag=%0d val=%h ardy=%0b exp tag=%0d", i, cdb_valid, cdb_tag, cdb_value, alu_ready, i);
        end
      end
      step();
    end
    checks++;
    if (cdb_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_drained got=%0b exp=0", cdb_valid); end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_push();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_freeze();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
